// File: rtl/div_res_bcd.sv
// Converts the divider's quotient/remainder to packed BCD with a serial double-dabble.
// Optional build macro LEAD_ZERO_BLANK_EN replaces leading zero digits with 4'hF.
module div_res_bcd #(
  parameter int N      = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_error,
  input  logic [N-1:0]          Q,
  input  logic [N-1:0]          R,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic [4*DIGITS-1:0]   r_bcd,
  output logic                  err,
  output logic                  busy,
  output logic                  out_valid
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONV_Q, CONV_R, FIN} state_t;

  state_t          state_q, state_d;
  logic            in_valid_dly_q;
  logic [5:0]      cnt_q, cnt_d;
  logic [N-1:0]    bq_q, bq_d, br_q, br_d;
  logic [BW-1:0]   qacc_q, qacc_d, racc_q, racc_d;
  logic            erf_q, erf_d;
  logic [BW-1:0]   q_out_q, q_out_d, r_out_q, r_out_d;
  logic            err_q, err_d;
  logic            vld_q, vld_d;
  logic            start;
  logic [BW-1:0]   q_fmt, r_fmt;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] acc, input logic b);
    logic [BW-1:0] t;
    for (int i = 0; i < DIGITS; i++) begin
      t[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end
    return {t[BW-2:0], b};
  endfunction

`ifdef LEAD_ZERO_BLANK_EN
  // Blank zero digits from the top down; digit 0 always stays visible.
  function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] v);
    logic [BW-1:0] t;
    logic          lead;
    t    = v;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'd0)) t[4*i +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
    return t;
  endfunction

  assign q_fmt = blank_lz(qacc_q);
  assign r_fmt = blank_lz(racc_q);
`else
  assign q_fmt = qacc_q;
  assign r_fmt = racc_q;
`endif

  assign start = in_valid & ~in_valid_dly_q & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bq_d    = bq_q;
    br_d    = br_q;
    qacc_d  = qacc_q;
    racc_d  = racc_q;
    erf_d   = erf_q;
    q_out_d = q_out_q;
    r_out_d = r_out_q;
    err_d   = err_q;
    vld_d   = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          bq_d    = Q;
          br_d    = R;
          qacc_d  = '0;
          racc_d  = '0;
          cnt_d   = '0;
          erf_d   = in_error;
          state_d = CONV_Q;
        end
      end
      CONV_Q: begin
        // A divide-by-zero skips conversion and reaches FIN one clock after start.
        if (erf_q) begin
          state_d = FIN;
        end else begin
          qacc_d = dd_step(qacc_q, bq_q[N-1]);
          bq_d   = {bq_q[N-2:0], 1'b0};
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == 6'(N - 1)) begin
            cnt_d   = '0;
            state_d = CONV_R;
          end
        end
      end
      CONV_R: begin
        racc_d = dd_step(racc_q, br_q[N-1]);
        br_d   = {br_q[N-2:0], 1'b0};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'(N - 1)) begin
          cnt_d   = '0;
          state_d = FIN;
        end
      end
      FIN: begin
        vld_d   = 1'b1;
        state_d = IDLE;
        if (erf_q) begin
          err_d   = 1'b1;
          q_out_d = '1;
          r_out_d = '1;
        end else begin
          err_d   = 1'b0;
          q_out_d = q_fmt;
          r_out_d = r_fmt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      in_valid_dly_q <= 1'b0;
      cnt_q          <= '0;
      bq_q           <= '0;
      br_q           <= '0;
      qacc_q         <= '0;
      racc_q         <= '0;
      erf_q          <= 1'b0;
      q_out_q        <= '0;
      r_out_q        <= '0;
      err_q          <= 1'b0;
      vld_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_valid_dly_q <= in_valid;
      cnt_q          <= cnt_d;
      bq_q           <= bq_d;
      br_q           <= br_d;
      qacc_q         <= qacc_d;
      racc_q         <= racc_d;
      erf_q          <= erf_d;
      q_out_q        <= q_out_d;
      r_out_q        <= r_out_d;
      err_q          <= err_d;
      vld_q          <= vld_d;
    end
  end

  assign q_bcd     = q_out_q;
  assign r_bcd     = r_out_q;
  assign err       = err_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_div_res_bcd.sv
// Directed bench for div_res_bcd: latency, conversions, error path, edge handling, reset abort.
`ifdef LEAD_ZERO_BLANK_EN
  `define EXP(p, b) (b)
`else
  `define EXP(p, b) (p)
`endif

module tb_div_res_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_error;
  logic [31:0] Q, R;
  logic [39:0] q_bcd, r_bcd;
  logic        err, busy, out_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_res_bcd dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_error  (in_error),
    .Q         (Q),
    .R         (R),
    .q_bcd     (q_bcd),
    .r_bcd     (r_bcd),
    .err       (err),
    .busy      (busy),
    .out_valid (out_valid)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with in_valid low; raises in_valid and waits for the result.
  task automatic run(input string tag, input logic [31:0] q, input logic [31:0] r,
                     input logic e, input int lat,
                     input logic [39:0] eq, input logic [39:0] er, input logic eerr);
    int n;
    n        = 0;
    Q        = q;
    R        = r;
    in_error = e;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) chk({tag, ".busy_start"}, 40'(busy), 40'd1);
      if (out_valid) break;
    end
    chk({tag, ".latency"}, 40'(n), 40'(lat));
    chk({tag, ".q_bcd"}, q_bcd, eq);
    chk({tag, ".r_bcd"}, r_bcd, er);
    chk({tag, ".err"}, 40'(err), 40'(eerr));
    in_valid = 1'b0;
    in_error = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".pulse_end"}, 40'(out_valid), 40'd0);
    chk({tag, ".idle"}, 40'(busy), 40'd0);
    chk({tag, ".hold_q"}, q_bcd, eq);
  endtask

  initial begin
    int pulses;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_error = 1'b0;
    Q        = '0;
    R        = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.q_bcd", q_bcd, 40'h0);
    chk("reset.r_bcd", r_bcd, 40'h0);
    chk("reset.err", 40'(err), 40'd0);
    chk("reset.busy", 40'(busy), 40'd0);
    chk("reset.out_valid", 40'(out_valid), 40'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("normal", 32'd123456789, 32'd7, 1'b0, 66,
        `EXP(40'h0123456789, 40'hF123456789), `EXP(40'h0000000007, 40'hFFFFFFFFF7), 1'b0);
    run("max", 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 66,
        40'h4294967295, 40'h4294967294, 1'b0);
    run("div0", 32'hxxxxxxxx, 32'hxxxxxxxx, 1'b1, 3,
        40'hFFFFFFFFFF, 40'hFFFFFFFFFF, 1'b1);
    run("clear_err", 32'd10, 32'd3, 1'b0, 66,
        `EXP(40'h0000000010, 40'hFFFFFFFF10), `EXP(40'h0000000003, 40'hFFFFFFFFF3), 1'b0);

    // Level held high for 200 clocks: one result only.
    Q        = 32'd5;
    R        = 32'd0;
    in_valid = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("held.pulses", 40'(pulses), 40'd1);
    chk("held.q_bcd", q_bcd, `EXP(40'h0000000005, 40'hFFFFFFFFF5));
    in_valid = 1'b0;
    @(posedge clk); #1;

    // A second rising edge during conversion is dropped.
    Q        = 32'd42;
    in_valid = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 110; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
      if (i == 9) in_valid = 1'b0;
      if (i == 10) begin
        Q        = 32'd77;
        in_valid = 1'b1;
      end
    end
    chk("busy_drop.pulses", 40'(pulses), 40'd1);
    chk("busy_drop.q_bcd", q_bcd, `EXP(40'h0000000042, 40'hFFFFFFFF42));
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a conversion.
    Q        = 32'd1000;
    R        = 32'd0;
    in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst.q_bcd", q_bcd, 40'h0);
    chk("midrst.r_bcd", r_bcd, 40'h0);
    chk("midrst.err", 40'(err), 40'd0);
    chk("midrst.busy", 40'(busy), 40'd0);
    chk("midrst.out_valid", 40'(out_valid), 40'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("midrst.no_pulse", 40'(pulses), 40'd0);
    run("after_rst", 32'd1000, 32'd0, 1'b0, 66,
        `EXP(40'h0000001000, 40'hFFFFFF1000), `EXP(40'h0000000000, 40'hFFFFFFFFF0), 1'b0);

    run("zero_305", 32'd0, 32'd305, 1'b0, 66,
        `EXP(40'h0000000000, 40'hFFFFFFFFF0), `EXP(40'h0000000305, 40'hFFFFFFF305), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
